core_pipe_lsu: RTL

CORE_PIPE_LSU -- requirements
Module: core_pipe_lsu

---
 rtl/core_pipe_lsu.sv | 212 +++++++++++++++++++++
 1 files changed

// File: rtl/core_pipe_lsu.sv
// Load/store unit: one sized memory access per valid/ready op, lane steering and load extension.
// Build option CORE_LSU_MISALIGN_EN: word-crossing accesses are split into two bus beats.
module core_pipe_lsu #(
   parameter int XLEN       = 64,
   parameter int MEM_ADDR_W = 64
) (
   input  logic                  g_clk,
   input  logic                  g_resetn,
   input  logic                  valid,
   input  logic [XLEN-1:0]       addr,
   input  logic [XLEN-1:0]       wdata,
   input  logic                  load,
   input  logic                  store,
   input  logic                  d_double,
   input  logic                  d_word,
   input  logic                  d_half,
   input  logic                  d_byte,
   input  logic                  sext,
   output logic                  ready,
   output logic                  trap_bus,
   output logic                  trap_addr,
   output logic [XLEN-1:0]       rdata,
   output logic                  dmem_req,
   output logic [MEM_ADDR_W-1:0] dmem_addr,
   output logic                  dmem_wen,
   output logic [XLEN/8-1:0]     dmem_strb,
   output logic [XLEN-1:0]       dmem_wdata,
   input  logic                  dmem_gnt,
   input  logic                  dmem_rsp,
   input  logic                  dmem_err,
   input  logic [XLEN-1:0]       dmem_rdata,
   output logic [2:0]            dbg_state
);
   // Handshakes: valid is held until the single-cycle ready pulse; dmem_req is held with
   // stable address/data until the cycle dmem_gnt is high; one dmem_rsp per grant, after it.
   localparam int NB = XLEN / 8;
   localparam int LB = $clog2(NB);
`ifdef CORE_LSU_MISALIGN_EN
   localparam int SPAN = 2;
`else
   localparam int SPAN = 1;
`endif

   typedef enum logic [2:0] {
      S_IDLE = 3'd0, S_REQ = 3'd1, S_RSP = 3'd2, S_DONE = 3'd3
`ifdef CORE_LSU_MISALIGN_EN
      , S_REQ2 = 3'd4, S_RSP2 = 3'd5
`endif
   } state_t;

   state_t                 state;
   logic [1:0]             in_lg;
   logic [SPAN*NB-1:0]     in_strb;
   logic [SPAN*XLEN-1:0]   in_wdata;
   logic [XLEN-1:0]        in_base;
   logic                   in_illegal;
   logic [LB-1:0]          c_off;
   logic [1:0]             c_lg;
   logic                   c_sext;
   logic                   c_store;
   logic [SPAN*XLEN-1:0]   rd_wide;
   logic [XLEN-1:0]        rd_low;
`ifdef CORE_LSU_MISALIGN_EN
   logic [XLEN-1:0]        in_base2;
   logic                   c_split;
   logic [NB-1:0]          c_strb_hi;
   logic [XLEN-1:0]        c_wdata_hi;
   logic [MEM_ADDR_W-1:0]  c_base2;
   logic [XLEN-1:0]        b1_data;
`endif

   assign dbg_state = state;

   function automatic logic [XLEN-1:0] extend(input logic [XLEN-1:0] raw, input logic [1:0] lg,
                                              input logic sx);
      logic [XLEN-1:0] keep;
      logic            sign;
      keep = ~({XLEN{1'b1}} << (8 << lg));
      case (lg)
         2'd0:    sign = raw[7];
         2'd1:    sign = raw[15];
         2'd2:    sign = raw[31];
         default: sign = raw[XLEN-1];
      endcase
      return (raw & keep) | ((sx && sign) ? ~keep : '0);
   endfunction

   always_comb begin
      in_lg = 2'd0;
      if (d_double)    in_lg = 2'd3;
      else if (d_word) in_lg = 2'd2;
      else if (d_half) in_lg = 2'd1;
      in_strb    = ~({(SPAN*NB){1'b1}} << (1 << in_lg)) << addr[LB-1:0];
      in_wdata   = (SPAN*XLEN)'(wdata) << {addr[LB-1:0], 3'b000};
      in_base    = {addr[XLEN-1:LB], {LB{1'b0}}};
      in_illegal = (load == store) || ($countones({d_double, d_word, d_half, d_byte}) != 1) ||
                   (d_double && XLEN == 32);
`ifdef CORE_LSU_MISALIGN_EN
      in_base2 = in_base + XLEN'(NB);
`else
      if ((addr[LB-1:0] & LB'((1 << in_lg) - 1)) != '0) in_illegal = 1'b1;
`endif
   end

   // Second beat supplies the high-address bytes, so it sits above beat 1 before the shift.
   always_comb begin
`ifdef CORE_LSU_MISALIGN_EN
      rd_wide = (state == S_RSP2) ? {dmem_rdata, b1_data} : {{XLEN{1'b0}}, dmem_rdata};
`else
      rd_wide = dmem_rdata;
`endif
      rd_low = XLEN'(rd_wide >> {c_off, 3'b000});
   end

   always_ff @(posedge g_clk or negedge g_resetn) begin
      if (!g_resetn) begin
         state      <= S_IDLE;
         ready      <= 1'b0;
         trap_bus   <= 1'b0;
         trap_addr  <= 1'b0;
         rdata      <= '0;
         dmem_req   <= 1'b0;
         dmem_addr  <= '0;
         dmem_wen   <= 1'b0;
         dmem_strb  <= '0;
         dmem_wdata <= '0;
         c_off      <= '0;
         c_lg       <= 2'd0;
         c_sext     <= 1'b0;
         c_store    <= 1'b0;
`ifdef CORE_LSU_MISALIGN_EN
         c_split    <= 1'b0;
         c_strb_hi  <= '0;
         c_wdata_hi <= '0;
         c_base2    <= '0;
         b1_data    <= '0;
`endif
      end else begin
         case (state)
            S_IDLE: if (valid) begin
               if (in_illegal) begin
                  state     <= S_DONE;
                  ready     <= 1'b1;
                  trap_addr <= 1'b1;
                  rdata     <= '0;
               end else begin
                  state      <= S_REQ;
                  dmem_req   <= 1'b1;
                  dmem_addr  <= in_base[MEM_ADDR_W-1:0];
                  dmem_wen   <= store;
                  dmem_strb  <= in_strb[NB-1:0];
                  dmem_wdata <= in_wdata[XLEN-1:0];
                  c_off      <= addr[LB-1:0];
                  c_lg       <= in_lg;
                  c_sext     <= sext;
                  c_store    <= store;
`ifdef CORE_LSU_MISALIGN_EN
                  c_split    <= |in_strb[2*NB-1:NB];
                  c_strb_hi  <= in_strb[2*NB-1:NB];
                  c_wdata_hi <= in_wdata[2*XLEN-1:XLEN];
                  c_base2    <= in_base2[MEM_ADDR_W-1:0];
`endif
               end
            end
            S_REQ: if (dmem_gnt) begin
               state    <= S_RSP;
               dmem_req <= 1'b0;
            end
            S_RSP: if (dmem_rsp) begin
               if (dmem_err) begin
                  state    <= S_DONE;
                  ready    <= 1'b1;
                  trap_bus <= 1'b1;
                  rdata    <= '0;
`ifdef CORE_LSU_MISALIGN_EN
               end else if (c_split) begin
                  state      <= S_REQ2;
                  b1_data    <= dmem_rdata;
                  dmem_req   <= 1'b1;
                  dmem_addr  <= c_base2;
                  dmem_strb  <= c_strb_hi;
                  dmem_wdata <= c_wdata_hi;
`endif
               end else begin
                  state <= S_DONE;
                  ready <= 1'b1;
                  rdata <= c_store ? '0 : extend(rd_low, c_lg, c_sext);
               end
            end
`ifdef CORE_LSU_MISALIGN_EN
            S_REQ2: if (dmem_gnt) begin
               state    <= S_RSP2;
               dmem_req <= 1'b0;
            end
            S_RSP2: if (dmem_rsp) begin
               state    <= S_DONE;
               ready    <= 1'b1;
               trap_bus <= dmem_err;
               rdata    <= (dmem_err || c_store) ? '0 : extend(rd_low, c_lg, c_sext);
            end
`endif
            S_DONE: begin
               state     <= S_IDLE;
               ready     <= 1'b0;
               trap_bus  <= 1'b0;
               trap_addr <= 1'b0;
            end
            default: state <= S_IDLE;
         endcase
      end
   end
endmodule
